// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external combinational ALU among NREQ requesters,
// returning each result with its requester index over a valid/ready response channel.
module alu_share_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1,
  parameter int OPW  = 12,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OPW-1:0]  req_op,
  input  logic [NREQ*DW-1:0]   req_src1,
  input  logic [NREQ*DW-1:0]   req_src2,
  output logic [OPW-1:0]       alu_control,
  output logic [DW-1:0]        alu_src1,
  output logic [DW-1:0]        alu_src2,
  input  logic [DW-1:0]        alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [DW-1:0]        rsp_data
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d, owner_q, winner, lo_w, hi_w;
  logic [OPW-1:0] op_q;
  logic [DW-1:0] src1_q, src2_q, rsp_data_q;
  logic [IDW-1:0] rsp_id_q;
  logic rsp_valid_q, lo_f, hi_f, can_accept, grant;
  // lowest valid index at/after the pointer wins, otherwise lowest valid index overall
  always_comb begin
    lo_f = 1'b0;
    hi_f = 1'b0;
    lo_w = '0;
    hi_w = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_f = 1'b1;
        lo_w = IDW'(i);
      end
      if (req_valid[i] && i >= int'(rr_q)) begin
        hi_f = 1'b1;
        hi_w = IDW'(i);
      end
    end
  end
  assign winner     = hi_f ? hi_w : lo_w;
  assign can_accept = (state_q == IDLE) || (state_q == RESP && rsp_ready);
  assign grant      = can_accept && lo_f;
  assign req_ready  = (grant && resetn) ? NREQ'(1) << winner : '0;
  always_comb begin
    state_d = (state_q == EXEC) ? RESP :
              grant ? EXEC :
              (state_q == RESP && !rsp_ready) ? RESP : IDLE;
    rr_d    = grant ? ((winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1) : rr_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      op_q        <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (grant) begin
        owner_q <= winner;
        op_q    <= req_op[winner*OPW +: OPW];
        src1_q  <= req_src1[winner*DW +: DW];
        src2_q  <= req_src2[winner*DW +: DW];
      end
      if (state_q == EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= owner_q;
        rsp_data_q  <= alu_result;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end
  assign alu_control = op_q;
  assign alu_src1    = src1_q;
  assign alu_src2    = src2_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: vector table, hand sequences for multi-cycle corners, and a randomized
// run checked against a transaction-level model of the arbitration and response rules.
module tb_alu_share_arbiter;
  localparam int NREQ = 2, IDW = 1, OPW = 12, DW = 32;
  logic clk = 1'b0, resetn = 1'b0;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*OPW-1:0] req_op;
  logic [NREQ*DW-1:0] req_src1, req_src2;
  logic [OPW-1:0] alu_control;
  logic [DW-1:0] alu_src1, alu_src2, alu_result, rsp_data;
  logic rsp_valid, rsp_ready;
  logic [IDW-1:0] rsp_id;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .OPW(OPW), .DW(DW)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
    .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data));
  function automatic logic [DW-1:0] alu_f(logic [OPW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    logic [DW-1:0] r = '0;
    if (op[0])  r |= a + b;
    if (op[1])  r |= a - b;
    if (op[2])  r |= DW'($signed(a) < $signed(b));
    if (op[3])  r |= DW'(a < b);
    if (op[4])  r |= a & b;
    if (op[5])  r |= a | b;
    if (op[6])  r |= a ^ b;
    if (op[7])  r |= a << b[4:0];
    if (op[8])  r |= a >> b[4:0];
    if (op[9])  r |= DW'($signed(a) >>> b[4:0]);
    if (op[10]) r |= b;
    if (op[11]) r |= ~(a | b);
    return r;
  endfunction
  assign alu_result = alu_f(alu_control, alu_src1, alu_src2);
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic set_req(int r, logic [OPW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    req_op[r*OPW +: OPW] = op;
    req_src1[r*DW +: DW] = a;
    req_src2[r*DW +: DW] = b;
  endtask
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask
  // one op from IDLE with rsp_ready held high: grant, EXEC, RESP, back to IDLE
  task automatic run_one(int r, logic [OPW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] exp);
    set_req(r, op, a, b);
    req_valid = NREQ'(1) << r;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("vec_grant", req_ready, NREQ'(1) << r);
    edge1();
    req_valid = '0;
    @(negedge clk);
    chk("vec_exec_valid", rsp_valid, 0);
    chk("vec_alu_control", alu_control, op);
    edge1();
    @(negedge clk);
    chk("vec_rsp_valid", rsp_valid, 1);
    chk("vec_rsp_id", rsp_id, r);
    chk("vec_rsp_data", rsp_data, exp);
    edge1();
    @(negedge clk);
    chk("vec_idle_valid", rsp_valid, 0);
    chk("vec_idle_ready", req_ready, 0);
    edge1();
  endtask
  typedef struct {int r; logic [OPW-1:0] op; logic [DW-1:0] a; logic [DW-1:0] b; logic [DW-1:0] exp;} vec_t;
  typedef struct {int id; logic [DW-1:0] d;} rsp_t;
  vec_t tv[6];
  rsp_t q[$];
  int g[4], rs[4], ng, nr, outstanding, acc, ptr_m, cyc, w;
  logic exp_rv;
  logic [NREQ-1:0] exp_rdy, last_rdy;
  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    tv[0] = '{0, 12'h001, 32'd5, 32'd7, 32'd12};
    tv[1] = '{0, 12'h002, 32'd3, 32'd10, 32'hFFFF_FFF9};
    tv[2] = '{1, 12'h004, 32'hFFFF_FFFF, 32'd1, 32'd1};
    tv[3] = '{1, 12'h008, 32'hFFFF_FFFF, 32'd1, 32'd0};
    tv[4] = '{0, 12'h000, 32'd123, 32'd456, 32'd0};
    tv[5] = '{1, 12'h400, 32'd0, 32'h0000_ABCD, 32'h0000_ABCD};
    req_op = '0;
    req_src1 = '0;
    req_src2 = '0;
    req_valid = '1;
    rsp_ready = 1'b1;
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_alu_control", alu_control, 0);
    chk("rst_alu_src", {alu_src1, alu_src2}, 0);
    do_reset();
    // contention from reset: both requesters always pending
    set_req(0, 12'h001, 32'd1, 32'd1);
    set_req(1, 12'h001, 32'd10, 32'd10);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      @(negedge clk);
      if (req_ready != 0 && ng < 4) begin
        g[ng] = int'(req_ready[1]);
        ng++;
      end
      if (rsp_valid && nr < 4) begin
        rs[nr] = int'(rsp_id);
        chk("cont_data", rsp_data, rsp_id ? 32'd20 : 32'd2);
        nr++;
      end
      edge1();
      if (ng == 4) req_valid = '0;
    end
    chk("cont_rsp_count", nr, 4);
    for (int i = 0; i < 4; i++) begin
      chk("cont_grant_order", g[i], i % 2);
      chk("cont_rsp_order", rs[i], i % 2);
    end
    for (int i = 0; i < 6; i++) run_one(tv[i].r, tv[i].op, tv[i].a, tv[i].b, tv[i].exp);
    // backpressure with req1 waiting
    rsp_ready = 1'b0;
    set_req(0, 12'h001, 32'd3, 32'd4);
    req_valid = 2'b01;
    @(negedge clk);
    chk("bp_grant0", req_ready, 2'b01);
    edge1();
    set_req(1, 12'h001, 32'd100, 32'd23);
    req_valid = 2'b10;
    @(negedge clk);
    chk("bp_exec_ready", req_ready, 0);
    edge1();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_id", rsp_id, 0);
      chk("bp_hold_data", rsp_data, 7);
      chk("bp_hold_ready", req_ready, 0);
      edge1();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_grant", req_ready, 2'b10);
    chk("bp_release_valid", rsp_valid, 1);
    edge1();
    req_valid = '0;
    @(negedge clk);
    chk("bp_exec2_valid", rsp_valid, 0);
    edge1();
    @(negedge clk);
    chk("bp_rsp1_valid", rsp_valid, 1);
    chk("bp_rsp1_id", rsp_id, 1);
    chk("bp_rsp1_data", rsp_data, 123);
    edge1();
    // back-to-back slt then sltu from req1
    set_req(1, 12'h004, 32'hFFFF_FFFF, 32'd1);
    req_valid = 2'b10;
    @(negedge clk);
    chk("b2b_grant_a", req_ready, 2'b10);
    edge1();
    set_req(1, 12'h008, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    chk("b2b_exec_ready", req_ready, 0);
    chk("b2b_exec_valid", rsp_valid, 0);
    edge1();
    @(negedge clk);
    chk("b2b_rsp_a_valid", rsp_valid, 1);
    chk("b2b_rsp_a_data", rsp_data, 1);
    chk("b2b_grant_b", req_ready, 2'b10);
    edge1();
    req_valid = '0;
    @(negedge clk);
    chk("b2b_gap_valid", rsp_valid, 0);
    edge1();
    @(negedge clk);
    chk("b2b_rsp_b_valid", rsp_valid, 1);
    chk("b2b_rsp_b_id", rsp_id, 1);
    chk("b2b_rsp_b_data", rsp_data, 0);
    edge1();
    // async reset while EXEC; pointer was left at 1 by granting req0
    set_req(0, 12'h001, 32'd2, 32'd2);
    set_req(1, 12'h001, 32'd40, 32'd2);
    req_valid = 2'b01;
    @(negedge clk);
    chk("ar_grant0", req_ready, 2'b01);
    edge1();
    req_valid = 2'b11;
    resetn = 1'b0;
    #1;
    chk("ar_alu_control", alu_control, 0);
    chk("ar_alu_src", {alu_src1, alu_src2}, 0);
    chk("ar_rsp", {rsp_valid, rsp_id, rsp_data}, 0);
    chk("ar_req_ready", req_ready, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("ar_no_rsp", rsp_valid, 0);
    end
    edge1();
    resetn = 1'b1;
    @(negedge clk);
    chk("ar_ptr_zero", req_ready, 2'b01);
    edge1();
    req_valid = 2'b10;
    @(negedge clk);
    chk("ar_exec_ready", req_ready, 0);
    edge1();
    @(negedge clk);
    chk("ar_rsp0", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, 32'd4});
    chk("ar_grant1", req_ready, 2'b10);
    edge1();
    req_valid = '0;
    edge1();
    @(negedge clk);
    chk("ar_rsp1", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b1, 32'd42});
    edge1();
    // randomized traffic against the transaction model
    do_reset();
    outstanding = 0;
    acc = -10;
    ptr_m = 0;
    cyc = 0;
    last_rdy = '0;
    q.delete();
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || last_rdy[i]) begin
          int b;
          b = $urandom_range(0, 12);
          req_valid[i] = 1'($urandom_range(0, 1));
          set_req(i, b == 12 ? 12'h000 : 12'h001 << b, $urandom, $urandom_range(0, 40));
        end
      end
      rsp_ready = $urandom_range(0, 9) < 7;
      @(negedge clk);
      exp_rv = outstanding == 1 && cyc >= acc + 2;
      chk("rnd_rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) begin
        chk("rnd_rsp_id", rsp_id, q[0].id);
        chk("rnd_rsp_data", rsp_data, q[0].d);
      end
      w = -1;
      if (outstanding == 0 || (exp_rv && rsp_ready))
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (ptr_m + k) % NREQ;
          if (w < 0 && req_valid[idx]) w = idx;
        end
      exp_rdy = w < 0 ? '0 : NREQ'(1) << w;
      chk("rnd_req_ready", req_ready, exp_rdy);
      if (exp_rv && rsp_ready) begin
        void'(q.pop_front());
        outstanding = 0;
      end
      if (w >= 0) begin
        q.push_back('{w, alu_f(req_op[w*OPW +: OPW], req_src1[w*DW +: DW], req_src2[w*DW +: DW])});
        outstanding = 1;
        acc = cyc;
        ptr_m = (w + 1) % NREQ;
      end
      last_rdy = exp_rdy;
      edge1();
      cyc++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
